// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory port arbiter
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } arb_state_e;

   localparam logic SRC_IF = 1'b0;
   localparam logic SRC_D  = 1'b1;

   localparam int INSTR_W = 32;
   localparam int DATA_W  = 64;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester handshakes and memory bus bundle
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 6
);
   import mem_arb_pkg::*;

   logic               if_req;
   logic [ADDR_W-1:0]  if_addr;
   logic               if_gnt;
   logic               if_rvalid;
   logic [INSTR_W-1:0] if_rdata;

   logic               d_req;
   logic               d_we;
   logic [ADDR_W-1:0]  d_addr;
   logic [DATA_W-1:0]  d_wdata;
   logic               d_gnt;
   logic               d_rvalid;
   logic [DATA_W-1:0]  d_rdata;

   logic               mem_en;
   logic               mem_sel;
   logic [ADDR_W-1:0]  mem_addr;
   logic               mem_we;
   logic [DATA_W-1:0]  mem_wdata;
   logic [DATA_W-1:0]  mem_rdata;

   logic               busy;

   // environment side: requesters and the memory array
   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
      input  mem_en, mem_sel, mem_addr, mem_we, mem_wdata, busy
   );

   // arbiter side
   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
      output mem_en, mem_sel, mem_addr, mem_we, mem_wdata, busy
   );

endinterface

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - data-first priority pick with fetch starvation guard
module mem_arb_pick #(
   parameter int STARVE_MAX = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic allow,
   input  logic if_req,
   input  logic d_req,
   output logic if_gnt,
   output logic d_gnt
);

   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

   logic [SW-1:0] starve_q;
   logic [SW-1:0] starve_d;
   logic          fetch_forced;

   // pick one winner; count data wins that overtook a waiting fetch
   always_comb begin
      if_gnt       = 1'b0;
      d_gnt        = 1'b0;
      starve_d     = starve_q;
      fetch_forced = if_req && (starve_q == STARVE_LIM);
      if (allow) begin
         if (d_req && !fetch_forced) begin
            d_gnt = 1'b1;
         end else if (if_req) begin
            if_gnt = 1'b1;
         end
      end
      if (if_gnt) begin
         starve_d = '0;
      end else if (d_gnt && if_req && (starve_q != STARVE_LIM)) begin
         starve_d = starve_q + 1'b1;
      end
   end

   // starvation counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shared memory port arbiter: FSM, latency counter, access latches
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = 6,
   parameter int LAT        = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic clk,
   input  logic rst_n,
   mem_port_arbiter_if.slave bus
);

   localparam int CW = $clog2(LAT + 1);
   localparam logic [CW-1:0] LAT_C = CW'(LAT);
   localparam logic [CW-1:0] ONE_C = CW'(1);

   arb_state_e          state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                src_q, src_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [INSTR_W-1:0]  if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

   logic allow;
   logic if_gnt;
   logic d_gnt;

   // grants only when the port is free; held off while reset is asserted
   assign allow = rst_n && (state_q != WAIT);

   mem_arb_pick #(
      .STARVE_MAX (STARVE_MAX)
   ) u_pick (
      .clk    (clk),
      .rst_n  (rst_n),
      .allow  (allow),
      .if_req (bus.if_req),
      .d_req  (bus.d_req),
      .if_gnt (if_gnt),
      .d_gnt  (d_gnt)
   );

   // next state: accept a request, count down the access, capture read data
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      src_d      = src_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;
      unique case (state_q)
         IDLE, RESP: begin
            if (if_gnt || d_gnt) begin
               state_d = WAIT;
               cnt_d   = LAT_C;
               src_d   = d_gnt ? SRC_D : SRC_IF;
               we_d    = d_gnt && bus.d_we;
               addr_d  = d_gnt ? bus.d_addr : bus.if_addr;
               if (d_gnt) begin
                  wdata_d = bus.d_wdata;
               end
            end else begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            cnt_d = cnt_q - ONE_C;
            if (cnt_q == ONE_C) begin
               state_d = RESP;
               if (src_q == SRC_IF) begin
                  if_rdata_d = bus.mem_rdata[INSTR_W-1:0];
               end else if (!we_q) begin
                  d_rdata_d = bus.mem_rdata;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // state, counter and latch registers; reset aborts any access in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         src_q      <= SRC_IF;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         src_q      <= src_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
      end
   end

   assign bus.if_gnt    = if_gnt;
   assign bus.d_gnt     = d_gnt;
   assign bus.mem_en    = (state_q == WAIT);
   assign bus.mem_sel   = src_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   // the memory write is level-sensitive: strobe only in the first WAIT cycle
   assign bus.mem_we    = (state_q == WAIT) && we_q && (cnt_q == LAT_C);
   assign bus.if_rvalid = (state_q == RESP) && (src_q == SRC_IF);
   assign bus.d_rvalid  = (state_q == RESP) && (src_q == SRC_D);
   assign bus.if_rdata  = if_rdata_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.busy      = (state_q == WAIT);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   localparam int ADDR_W     = 6;
   localparam int LAT        = 2;
   localparam int STARVE_MAX = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

   mem_port_arbiter #(
      .ADDR_W     (ADDR_W),
      .LAT        (LAT),
      .STARVE_MAX (STARVE_MAX)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;
   int tcyc = 0;
   always @(posedge clk) tcyc <= tcyc + 1;

   function automatic logic [63:0] h(input int a, input int salt);
      logic [63:0] x;
      x = {a, salt};
      return (x ^ 64'h5DEECE66D) * 64'hD6E8FEB86659FD93;
   endfunction

   function automatic logic [63:0] scr(input int c);
      return h(c, 77);
   endfunction

   // memory array behind the port; read data is only meaningful in the cycle it is presented
   logic [63:0] dmem [64];
   bit init_done;
   always @(posedge clk) begin
      if (!init_done) begin
         for (int i = 0; i < 64; i++) dmem[i] <= h(i, 9);
         init_done <= 1'b1;
      end else if (bus.mem_we && bus.mem_sel) begin
         dmem[bus.mem_addr] <= bus.mem_wdata;
      end
   end

   always_comb begin
      bus.mem_rdata = 64'hA5A5_5A5A_0BAD_F00D;
      if (bus.mem_en)
         bus.mem_rdata = (bus.mem_sel ? dmem[bus.mem_addr] : h(int'(bus.mem_addr), 5)) ^ scr(tcyc);
   end

   typedef struct {
      bit          src;
      bit          st;
      logic [63:0] data;
      int          due;
   } resp_t;
   resp_t sbq[$];

   logic [63:0] ref_dmem [64];
   int          gnt_cyc = -100;
   bit          cur_src, cur_we;
   logic [5:0]  cur_addr;
   logic [63:0] cur_wdata;
   int          starve = 0;
   logic [31:0] exp_if_rdata = '0;
   logic [63:0] exp_d_rdata = '0;
   logic [63:0] undo_val;
   bit          last_g_if, last_g_d, obs_d_gnt;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, tcyc);
      end
   endtask

   // one clock of the reference model: port is held LAT cycles after each grant,
   // data beats fetch unless fetch has been overtaken STARVE_MAX times in a row
   task automatic step();
      bit ex_en, ex_we, eg_if, eg_d;
      resp_t r;
      logic [63:0] v;
      @(negedge clk);
      ex_en = (tcyc > gnt_cyc) && (tcyc <= gnt_cyc + LAT);
      ex_we = ex_en && cur_we && (tcyc == gnt_cyc + 1);
      chk("mem_en", 64'(bus.mem_en), 64'(ex_en));
      chk("busy", 64'(bus.busy), 64'(ex_en));
      chk("mem_we", 64'(bus.mem_we), 64'(ex_we));
      if (ex_en) begin
         chk("mem_sel", 64'(bus.mem_sel), 64'(cur_src));
         chk("mem_addr", 64'(bus.mem_addr), 64'(cur_addr));
         if (cur_we) chk("mem_wdata", bus.mem_wdata, cur_wdata);
      end
      eg_d  = !ex_en && bus.d_req && !(bus.if_req && starve == STARVE_MAX);
      eg_if = !ex_en && bus.if_req && !eg_d;
      obs_d_gnt = bus.d_gnt;
      chk("d_gnt", 64'(bus.d_gnt), 64'(eg_d));
      chk("if_gnt", 64'(bus.if_gnt), 64'(eg_if));
      if (eg_if) starve = 0;
      else if (eg_d && bus.if_req && starve < STARVE_MAX) starve++;
      if (eg_if || eg_d) begin
         gnt_cyc   = tcyc;
         cur_src   = eg_d;
         cur_addr  = eg_d ? bus.d_addr : bus.if_addr;
         cur_we    = eg_d && bus.d_we;
         cur_wdata = bus.d_wdata;
         r.src = eg_d;
         r.st  = cur_we;
         r.due = tcyc + LAT + 1;
         if (cur_we) begin
            undo_val = ref_dmem[cur_addr];
            ref_dmem[cur_addr] = cur_wdata;
            r.data = '0;
         end else begin
            v = eg_d ? ref_dmem[cur_addr] : h(int'(cur_addr), 5);
            r.data = v ^ scr(tcyc + LAT);
            if (!eg_d) r.data[63:32] = '0;
         end
         sbq.push_back(r);
      end
      last_g_if = eg_if;
      last_g_d  = eg_d;
      @(posedge clk);
      #1;
      if (last_g_if) bus.if_req = 1'b0;
      if (last_g_d) bus.d_req = 1'b0;
   endtask

   task automatic idle_steps(input int n);
      bus.if_req = 1'b0;
      bus.d_req  = 1'b0;
      repeat (n) step();
   endtask

   task automatic wait_d_gnt(input string name);
      int k;
      k = 0;
      do begin
         step();
         k++;
      end while (!last_g_d && k < 20);
      if (!last_g_d) begin
         checks++;
         errors++;
         $display("FAIL %s: no data grant within 20 cycles", name);
      end
   endtask

   // response monitor: every rvalid must match the oldest outstanding expectation
   initial begin
      resp_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (sbq.size() > 0 && sbq[0].due < tcyc) begin
               checks++;
               errors++;
               $display("FAIL missing_rvalid: got no rvalid, expected at cycle %0d", sbq[0].due);
               void'(sbq.pop_front());
            end
            if (bus.if_rvalid || bus.d_rvalid) begin
               chk("single_rvalid", 64'(bus.if_rvalid & bus.d_rvalid), 64'(0));
               if (sbq.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_rvalid: got if=%0b d=%0b expected none at cycle %0d",
                           bus.if_rvalid, bus.d_rvalid, tcyc);
               end else begin
                  e = sbq.pop_front();
                  chk("rvalid_src", 64'(bus.d_rvalid), 64'(e.src));
                  chk("rvalid_cycle", 64'(tcyc), 64'(e.due));
                  if (e.src) begin
                     if (!e.st) exp_d_rdata = e.data;
                  end else begin
                     exp_if_rdata = e.data[31:0];
                  end
                  chk("if_rdata", 64'(bus.if_rdata), 64'(exp_if_rdata));
                  chk("d_rdata", bus.d_rdata, exp_d_rdata);
               end
            end
         end
      end
   end

   initial begin
      string seq;
      int    g1, k;
      for (int i = 0; i < 64; i++) ref_dmem[i] = h(i, 9);
      bus.if_req  = 1'b0;
      bus.if_addr = '0;
      bus.d_req   = 1'b0;
      bus.d_we    = 1'b0;
      bus.d_addr  = '0;
      bus.d_wdata = '0;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_mem_en", 64'(bus.mem_en), 64'(0));
      chk("rst_mem_we", 64'(bus.mem_we), 64'(0));
      chk("rst_busy", 64'(bus.busy), 64'(0));
      chk("rst_if_rvalid", 64'(bus.if_rvalid), 64'(0));
      chk("rst_d_rvalid", 64'(bus.d_rvalid), 64'(0));
      chk("rst_if_rdata", 64'(bus.if_rdata), 64'(0));
      chk("rst_d_rdata", bus.d_rdata, 64'(0));
      chk("rst_mem_addr", 64'(bus.mem_addr), 64'(0));
      @(posedge clk);
      #1 rst_n = 1'b1;

      // fetch only
      bus.if_req  = 1'b1;
      bus.if_addr = 6'd4;
      step();
      idle_steps(3);

      // store then load back the same word
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 6'd3; bus.d_wdata = 64'd50;
      step();
      idle_steps(3);
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 6'd3;
      step();
      idle_steps(3);

      // contention: both held high continuously
      seq = "";
      for (k = 0; k < 100 && seq.len() < 10; k++) begin
         bus.if_req = 1'b1;
         bus.d_req  = 1'b1;
         bus.d_we   = 1'b0;
         step();
         if (last_g_d) seq = {seq, "D"};
         else if (last_g_if) seq = {seq, "I"};
      end
      checks++;
      if (seq != "DDDDIDDDDI") begin
         errors++;
         $display("FAIL contention_order: got %s expected DDDDIDDDDI", seq);
      end
      idle_steps(4);

      // back-to-back loads
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 6'd1;
      wait_d_gnt("b2b_first");
      g1 = gnt_cyc;
      bus.d_req = 1'b1; bus.d_addr = 6'd2;
      wait_d_gnt("b2b_second");
      chk("b2b_gap", 64'(gnt_cyc - g1), 64'(LAT + 1));
      idle_steps(4);

      // request withdrawal while the port is busy
      bus.if_req = 1'b1; bus.if_addr = 6'd9;
      step();
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 6'd7; bus.d_wdata = 64'hFEED;
      step();
      idle_steps(4);
      chk("withdraw_nowrite", dmem[7], ref_dmem[7]);

      // randomized traffic
      for (int n = 0; n < 500; n++) begin
         if (bus.if_req) begin
            if ($urandom_range(9) == 0) bus.if_req = 1'b0;
            else if ($urandom_range(4) == 0) bus.if_addr = ADDR_W'($urandom);
         end else if ($urandom_range(2) == 0) begin
            bus.if_req  = 1'b1;
            bus.if_addr = ADDR_W'($urandom);
         end
         if (bus.d_req) begin
            if ($urandom_range(9) == 0) bus.d_req = 1'b0;
            else if ($urandom_range(4) == 0) bus.d_addr = ADDR_W'($urandom_range(7));
         end else if ($urandom_range(2) == 0) begin
            bus.d_req   = 1'b1;
            bus.d_we    = 1'($urandom_range(1));
            bus.d_addr  = ADDR_W'($urandom_range(7));
            bus.d_wdata = {$urandom, $urandom};
         end
         step();
      end
      idle_steps(5);

      // reset in the first WAIT cycle of a store
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 6'd5; bus.d_wdata = 64'h1234_5678_9ABC_DEF0;
      step();
      chk("pre_reset_we", 64'(bus.mem_we), 64'(1));
      rst_n = 1'b0;
      bus.if_req = 1'b1;
      bus.d_req  = 1'b1;
      bus.d_we   = 1'b0;
      #1;
      chk("reset_mem_we", 64'(bus.mem_we), 64'(0));
      chk("reset_mem_en", 64'(bus.mem_en), 64'(0));
      chk("reset_busy", 64'(bus.busy), 64'(0));
      chk("reset_gnt", 64'({bus.if_gnt, bus.d_gnt}), 64'(0));
      chk("reset_rvalid", 64'({bus.if_rvalid, bus.d_rvalid}), 64'(0));
      chk("reset_rdata", bus.d_rdata | 64'(bus.if_rdata), 64'(0));
      sbq.delete();
      gnt_cyc      = -100;
      starve       = 0;
      exp_if_rdata = '0;
      exp_d_rdata  = '0;
      ref_dmem[5]  = undo_val;
      repeat (2) @(posedge clk);
      bus.if_req = 1'b0;
      #1 rst_n = 1'b1;
      step();
      chk("post_reset_gnt", 64'(obs_d_gnt), 64'(1));
      idle_steps(4);
      chk("abort_nowrite", dmem[5], undo_val);

      // drain
      k = 0;
      while (sbq.size() > 0 && k < 20) begin
         step();
         k++;
      end
      chk("scoreboard_empty", 64'(sbq.size()), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported unified instruction/data memory between the fetch stage (32-bit instruction reads) and the memory stage (64-bit data loads/stores).
- Provides a req/gnt/rvalid handshake per requester, sequences each access over a fixed memory latency, and pulses the write strobe exactly once per store.
- Data requests win by default; a starvation counter forces a fetch grant after a bounded run of data grants.

Parameters:
- ADDR_W, 6, word address width for both spaces.
- LAT, 2, cycles memory is held busy per access (LAT >= 1).
- STARVE_MAX, 4, consecutive data grants with if_req pending before fetch is forced (>= 1).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  ADDR_W  instruction word address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  one-cycle pulse, if_rdata valid
- if_rdata  out  32  fetched instruction
- d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data word address
- d_wdata  in  64  store data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  one-cycle pulse: load data valid, or store complete
- d_rdata  out  64  load data
- mem_en  out  1  memory access active
- mem_sel  out  1  0 = instruction space, 1 = data space
- mem_addr  out  ADDR_W  latched address
- mem_we  out  1  write strobe
- mem_wdata  out  64  latched store data
- mem_rdata  in  64  memory read data; instructions in bits [31:0]
- busy  out  1  high in WAIT

Behaviour:
- States: IDLE, WAIT, RESP.
- Grants are combinational, produced only in IDLE or RESP. Acceptance is req & gnt at a rising edge.
  - On acceptance: latch source, addr, we, and wdata; load the latency counter with LAT; go to WAIT.
  - With no acceptance: go to or stay in IDLE.
- Arbitration:
  - A lone requester is always granted.
  - When both requesters are active, data wins unless starve_cnt == STARVE_MAX, in which case fetch wins.
  - starve_cnt increments on each data grant while if_req = 1.
  - starve_cnt clears on any fetch grant.
  - starve_cnt saturates at STARVE_MAX.
  - At most one gnt is high per cycle.
- WAIT:
  - mem_en = 1; mem_sel, mem_addr and mem_wdata are driven from the latches and held stable.
  - mem_we = 1 only in the first WAIT cycle, and only for stores. The memory write is level-sensitive, so a single pulse is mandatory.
  - The counter decrements each cycle. On the last WAIT cycle (counter == 1), mem_rdata is captured into if_rdata (bits [31:0]) or d_rdata (loads only); then go to RESP.
- RESP:
  - The matching rvalid is high for exactly one cycle.
  - New grants are allowed in the same cycle, giving back-to-back throughput of one access per LAT+1 cycles.
  - mem_en = 0.
- Stores: d_rvalid pulses in RESP; d_rdata is unchanged.
- rdata registers hold their last value until the next response of the same type.
- A requester may drop req before gnt; no transaction results. Changing the address while req is high and gnt is low is legal; the value sampled at acceptance is used.
- Reset (asynchronous, any state):
  - State returns to IDLE; starve_cnt, the latency counter and all latches clear.
  - All outputs go to 0 immediately, including mem_we and rdata.
  - An in-flight access is aborted with no rvalid.
- Addresses and wdata are passed through without arithmetic. Space offset mapping belongs to the memory.

Decomposition:
- Package mem_arb_pkg:
  - State enum (IDLE/WAIT/RESP).
  - Source constants SRC_IF = 0, SRC_D = 1.
  - Width constants INSTR_W = 32 and DATA_W = 64.
- One natural sub-module, mem_arb_pick: combinational priority choice plus the starve_cnt register. The top level holds the FSM, latency counter and latches.

Test Plan:
- Fetch only (LAT=2). Stimulus: if_req=1, if_addr=4 in cycle 0. Required response:
  - if_gnt=1 in cycle 0.
  - mem_en=1 and mem_sel=0 in cycles 1-2.
  - if_rvalid=1 in cycle 3, with if_rdata = mem_rdata[31:0] from cycle 2.
- Store. Stimulus: d_req, d_we=1, d_addr=3, d_wdata=50. Required response:
  - mem_we=1 for exactly one cycle, with mem_addr=3 and mem_wdata=50.
  - d_rvalid pulses once; d_rdata is unchanged.
- Contention with STARVE_MAX=4. Stimulus: if_req and d_req both held high continuously. Required response: grant sequence D,D,D,D,I,D,D,D,D,I…; never two gnts in one cycle.
- Back-to-back data loads. Stimulus: loads to addresses 1 and 2. Required response: second d_gnt coincides with the first d_rvalid; rvalids occur every LAT+1=3 cycles.
- Reset mid-access. Stimulus: rst_n asserted low in the first WAIT cycle of a store. Required response:
  - mem_we and mem_en drop to 0 immediately; no rvalid.
  - After release, the state is IDLE and a new request is granted in its first cycle.
- Request withdrawal. Stimulus: d_req is raised for one cycle while the arbiter is in WAIT, then dropped. Required response: no d_gnt, and no data access occurs.
